// File: rtl/rx_ctrl_pkg.sv
// Shared types for the receive-chain sequencer: state encoding, rate codes and rate sanitising.
// Pure declarations; no latency, no flow control.
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_APPLY  = 2'd3
    } rx_state_t;

    localparam logic [7:0] RATE_48K  = 8'd0;
    localparam logic [7:0] RATE_96K  = 8'd1;
    localparam logic [7:0] RATE_192K = 8'd2;

    // Codes the decimation chain cannot run fall back to the base 48 kHz rate.
    function automatic logic [7:0] sanitise_rate(input logic [7:0] code, input logic [7:0] max_code);
        return (code > max_code) ? RATE_48K : code;
    endfunction

endpackage

// File: rtl/rx_edge_counter.sv
// Counts rising edges of decim_avail up to a loaded target; hit is combinational on the edge that reaches it.
// No backpressure: edges outside enable are dropped, the history register always tracks the input.
module rx_edge_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             decim_avail,
    input  logic             enable,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic             avail_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] count;
    logic             edge_seen;
    logic [CNT_W:0]   count_inc;

    assign edge_seen = decim_avail & ~avail_q;
    assign count_inc = (CNT_W+1)'(count) + (CNT_W+1)'(1);
    assign hit       = enable & edge_seen & (count_inc >= (CNT_W+1)'(target_q));

    always_ff @(posedge clock) begin
        if (reset) begin
            // History starts high so a level already asserted at reset is not an edge.
            avail_q  <= 1'b1;
            target_q <= '0;
            count    <= '0;
        end else begin
            avail_q <= decim_avail;
            if (load) begin
                target_q <= target;
                count    <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable && edge_seen && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_config_sequencer.sv
// Applies host tune/rate requests atomically, flushes CIC/FIR on rate change and blanks output until settled.
// Request to applied rx_freq/rx_rate is 2 cycles; a new cfg_strobe always aborts and restarts the sequence.
module rx_config_sequencer
    import rx_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES   = 64,
    parameter int SETTLE_RATE    = 8,
    parameter int SETTLE_FREQ    = 2,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RATE_CODE  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_strobe,
    input  logic [31:0] cfg_freq,
    input  logic [7:0]  cfg_rate,
    input  logic        decim_avail,
    output logic [31:0] rx_freq,
    output logic [7:0]  rx_rate,
    output logic        dsp_reset,
    output logic        out_enable,
    output logic        busy,
    output logic        cfg_done,
    output logic        settle_timeout
);

    localparam int SETTLE_MAX = (SETTLE_RATE > SETTLE_FREQ) ? SETTLE_RATE : SETTLE_FREQ;
    localparam int FLUSH_W    = $clog2(FLUSH_CYCLES) + 1;
    localparam int SETTLE_W   = $clog2(SETTLE_MAX) + 1;
    localparam int TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [7:0]          MAX_CODE     = 8'(MAX_RATE_CODE);
    localparam logic [TIMER_W-1:0]  TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

    rx_state_t           state;
    rx_state_t           state_next;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [TIMER_W-1:0]  settle_timer;
    logic [31:0]         shadow_freq;
    logic [7:0]          shadow_rate;
    logic [7:0]          san_rate;
    logic                flush_pend;
    logic                need_flush;
    logic                settle_load;
    logic [SETTLE_W-1:0] settle_target;
    logic                settle_hit;
    logic                timeout_hit;

    assign san_rate   = sanitise_rate(shadow_rate, MAX_CODE);
    // A back-to-back APPLY must not lose a flush decided by the one before it.
    assign need_flush = (san_rate != rx_rate) | flush_pend;

    assign dsp_reset  = (state == ST_FLUSH);
    assign out_enable = (state == ST_RUN);
    assign busy       = (state != ST_RUN);

    always_comb begin
        state_next    = state;
        settle_load   = 1'b0;
        settle_target = SETTLE_W'(SETTLE_FREQ);
        timeout_hit   = 1'b0;
        case (state)
            ST_RUN: begin
                if (cfg_strobe) state_next = ST_APPLY;
            end
            ST_APPLY: begin
                if (cfg_strobe) begin
                    state_next = ST_APPLY;
                end else if (need_flush) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next  = ST_SETTLE;
                    settle_load = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cfg_strobe) begin
                    state_next = ST_APPLY;
                end else if (flush_cnt <= FLUSH_W'(1)) begin
                    state_next    = ST_SETTLE;
                    settle_load   = 1'b1;
                    settle_target = SETTLE_W'(SETTLE_RATE);
                end
            end
            ST_SETTLE: begin
                if (cfg_strobe) begin
                    state_next = ST_APPLY;
                end else if (settle_hit) begin
                    state_next = ST_RUN;
                end else if (settle_timer == TIMER_LAST) begin
                    state_next  = ST_RUN;
                    timeout_hit = 1'b1;
                end
            end
            default: state_next = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_FLUSH;
            flush_cnt      <= FLUSH_W'(FLUSH_CYCLES);
            settle_timer   <= '0;
            shadow_freq    <= '0;
            shadow_rate    <= '0;
            flush_pend     <= 1'b0;
            rx_freq        <= '0;
            rx_rate        <= '0;
            cfg_done       <= 1'b0;
            settle_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            cfg_done <= (state_next == ST_RUN) && (state != ST_RUN);

            if (cfg_strobe) begin
                shadow_freq <= cfg_freq;
                shadow_rate <= cfg_rate;
            end

            if (state == ST_APPLY) begin
                rx_freq        <= shadow_freq;
                rx_rate        <= san_rate;
                settle_timeout <= 1'b0;
                flush_pend     <= cfg_strobe & need_flush;
            end else if (timeout_hit) begin
                settle_timeout <= 1'b1;
            end

            if (state == ST_APPLY) begin
                flush_cnt <= FLUSH_W'(FLUSH_CYCLES);
            end else if ((state == ST_FLUSH) && (flush_cnt != '0)) begin
                flush_cnt <= flush_cnt - FLUSH_W'(1);
            end

            if (state != ST_SETTLE) begin
                settle_timer <= '0;
            end else if (settle_timer != '1) begin
                settle_timer <= settle_timer + TIMER_W'(1);
            end
        end
    end

    rx_edge_counter #(
        .CNT_W (SETTLE_W)
    ) u_edge_counter (
        .clock       (clock),
        .reset       (reset),
        .decim_avail (decim_avail),
        .enable      (state == ST_SETTLE),
        .load        (settle_load),
        .clear       (state != ST_SETTLE),
        .target      (settle_target),
        .hit         (settle_hit)
    );

endmodule

// File: tb/tb_rx_config_sequencer.sv
// Scoreboarded bench for rx_config_sequencer: each request pushes its expected outcome, popped on cfg_done.
module tb_rx_config_sequencer;

    localparam int FLUSH_CYCLES   = 64;
    localparam int SETTLE_RATE    = 8;
    localparam int SETTLE_FREQ    = 2;
    localparam int TIMEOUT_CYCLES = 65536;
    localparam int MAX_RATE_CODE  = 2;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        cfg_strobe  = 1'b0;
    logic [31:0] cfg_freq    = '0;
    logic [7:0]  cfg_rate    = '0;
    logic        decim_avail = 1'b0;
    logic [31:0] rx_freq;
    logic [7:0]  rx_rate;
    logic        dsp_reset;
    logic        out_enable;
    logic        busy;
    logic        cfg_done;
    logic        settle_timeout;

    typedef struct {
        logic [31:0] freq;
        logic [7:0]  rate;
        logic        flush;
        logic        timeout;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       cur;
    int         n_checks   = 0;
    int         n_fail     = 0;
    logic       gen_en     = 1'b0;
    logic       apply_cyc  = 1'b0;
    logic [7:0] model_rate = 8'd0;

    int   flush_run  = 0;
    int   last_flush = 0;
    int   edge_cnt   = 0;
    int   settle_cyc = 0;
    logic flush_seen = 1'b0;
    logic avail_prev = 1'b1;
    logic done_prev  = 1'b0;

    rx_config_sequencer #(
        .FLUSH_CYCLES   (FLUSH_CYCLES),
        .SETTLE_RATE    (SETTLE_RATE),
        .SETTLE_FREQ    (SETTLE_FREQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RATE_CODE  (MAX_RATE_CODE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_strobe     (cfg_strobe),
        .cfg_freq       (cfg_freq),
        .cfg_rate       (cfg_rate),
        .decim_avail    (decim_avail),
        .rx_freq        (rx_freq),
        .rx_rate        (rx_rate),
        .dsp_reset      (dsp_reset),
        .out_enable     (out_enable),
        .busy           (busy),
        .cfg_done       (cfg_done),
        .settle_timeout (settle_timeout)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // decim_avail toggles every 40 cycles while enabled, otherwise held low.
    initial begin
        forever begin
            repeat (40) @(posedge clock);
            #1;
            if (gen_en) decim_avail = ~decim_avail;
            else        decim_avail = 1'b0;
        end
    end

    // Monitor: measures flush length, discarded edges and settle cycles, and scores each cfg_done.
    always @(negedge clock) begin
        if (reset) begin
            flush_run  = 0;
            last_flush = 0;
            edge_cnt   = 0;
            settle_cyc = 0;
            flush_seen = 1'b0;
            avail_prev = 1'b1;
            done_prev  = 1'b0;
        end else begin
            if (dsp_reset) begin
                flush_run++;
            end else if (flush_run != 0) begin
                last_flush = flush_run;
                flush_run  = 0;
            end
            if (cfg_strobe) begin
                edge_cnt   = 0;
                settle_cyc = 0;
                flush_seen = 1'b0;
            end else begin
                if (dsp_reset) flush_seen = 1'b1;
                if (busy && !dsp_reset && !apply_cyc) begin
                    settle_cyc++;
                    if (decim_avail && !avail_prev) edge_cnt++;
                end
            end
            if (done_prev) check_eq("done_pulse_width", cfg_done, 0);
            if (cfg_done) begin
                check_eq("done_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    check_eq("done_rx_freq", rx_freq, cur.freq);
                    check_eq("done_rx_rate", rx_rate, cur.rate);
                    check_eq("done_timeout_flag", settle_timeout, cur.timeout);
                    check_eq("done_flush_seen", flush_seen, cur.flush);
                    if (cur.flush) check_eq("flush_length", last_flush, FLUSH_CYCLES);
                    if (cur.timeout) check_eq("settle_cycles", settle_cyc, TIMEOUT_CYCLES);
                    else check_eq("settle_edges", edge_cnt, cur.flush ? SETTLE_RATE : SETTLE_FREQ);
                    check_eq("done_out_enable", out_enable, 1);
                    check_eq("done_busy", busy, 0);
                end
                edge_cnt   = 0;
                settle_cyc = 0;
                flush_seen = 1'b0;
            end
            done_prev  = cfg_done;
            avail_prev = decim_avail;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_strobe(input logic [31:0] f, input logic [7:0] r, input logic push, input logic exp_to);
        logic [7:0] san;
        exp_t       e;
        san       = (r > 8'(MAX_RATE_CODE)) ? 8'd0 : r;
        e.freq    = f;
        e.rate    = san;
        e.flush   = (san != model_rate);
        e.timeout = exp_to;
        model_rate = san;
        if (push) sb_q.push_back(e);
        cfg_freq   = f;
        cfg_rate   = r;
        cfg_strobe = 1'b1;
        tick();
        cfg_strobe = 1'b0;
        apply_cyc  = 1'b1;
        check_eq("apply_busy", busy, 1);
        check_eq("apply_out_enable", out_enable, 0);
        tick();
        apply_cyc = 1'b0;
        check_eq("t2_rx_freq", rx_freq, f);
        check_eq("t2_rx_rate", rx_rate, san);
        check_eq("t2_timeout_clear", settle_timeout, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_within_budget", n < budget, 1);
        repeat (3) tick();
        check_eq("run_out_enable", out_enable, 1);
    endtask

    initial begin
        exp_t e0;
        reset  = 1'b1;
        gen_en = 1'b1;
        repeat (3) tick();
        check_eq("rst_rx_freq", rx_freq, 0);
        check_eq("rst_rx_rate", rx_rate, 0);
        check_eq("rst_dsp_reset", dsp_reset, 1);
        check_eq("rst_out_enable", out_enable, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_cfg_done", cfg_done, 0);
        check_eq("rst_timeout", settle_timeout, 0);

        e0.freq = 32'd0; e0.rate = 8'd0; e0.flush = 1'b1; e0.timeout = 1'b0;
        sb_q.push_back(e0);
        reset = 1'b0;
        wait_idle(2000);

        do_strobe(32'd7074000, 8'd0, 1'b1, 1'b0);
        wait_idle(1000);
        do_strobe(32'd10000000, 8'd2, 1'b1, 1'b0);
        wait_idle(2000);
        do_strobe(32'd10000000, 8'd5, 1'b1, 1'b0);
        wait_idle(2000);
        do_strobe(32'd3000000, 8'd5, 1'b1, 1'b0);
        wait_idle(1000);

        do_strobe(32'd5000000, 8'd2, 1'b0, 1'b0);
        repeat (20) tick();
        check_eq("mid_flush_dsp_reset", dsp_reset, 1);
        do_strobe(32'd14074000, 8'd1, 1'b1, 1'b0);
        wait_idle(2000);

        gen_en = 1'b0;
        repeat (45) tick();
        check_eq("avail_held_low", decim_avail, 0);
        do_strobe(32'd1000000, 8'd1, 1'b1, 1'b1);
        wait_idle(TIMEOUT_CYCLES + 500);
        check_eq("timeout_sticky", settle_timeout, 1);

        gen_en = 1'b1;
        do_strobe(32'd2000000, 8'd1, 1'b1, 1'b0);
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_config_sequencer.md
Name: rx_config_sequencer

Overview:
- Sequences the receive DDC chain (CORDIC NCO, variable CIC stages, decimate-by-8 FIR) through safe retuning and rate changes.
- Latches host requests for tune word and rate code, applies them atomically, and flushes the CIC/FIR state when the rate changes.
- Blanks the I/Q output until the filters have produced a programmable number of settled samples.
- Sits between the host control interface and the receiver datapath. It drives the receiver's rx_freq and rx_rate, and it observes decim_avail.

Parameters:
FLUSH_CYCLES, 64, cycles that dsp_reset is held high after a rate change (minimum 1)
SETTLE_RATE, 8, decimated samples discarded after a rate change (minimum 1)
SETTLE_FREQ, 2, decimated samples discarded after a frequency-only change (minimum 1)
TIMEOUT_CYCLES, 65536, maximum number of cycles spent in SETTLE
MAX_RATE_CODE, 2, highest legal rate code; larger codes map to 0 (48 kHz)

Ports:
clock  in  1  system clock (ADC sample clock domain)
reset  in  1  synchronous, active-high reset
cfg_strobe  in  1  single-cycle request to apply cfg_freq/cfg_rate
cfg_freq  in  32  requested tune frequency in Hz
cfg_rate  in  8  requested rate code
decim_avail  in  1  FIR output-available level; a rising edge marks one new sample
rx_freq  out  32  applied tune frequency, to the receiver
rx_rate  out  8  applied, sanitised rate code, to the receiver
dsp_reset  out  1  synchronous clear for the CIC/FIR state
out_enable  out  1  high only while rx_real/rx_imag carry settled data
busy  out  1  high in every state except RUN
cfg_done  out  1  one-cycle pulse on entry to RUN
settle_timeout  out  1  sticky flag: SETTLE ended by timeout

Behaviour:
- Reset values:
  - rx_freq=0, rx_rate=0, dsp_reset=1, out_enable=0, busy=1, cfg_done=0, settle_timeout=0.
  - Edge-detect history register = 1, so a high decim_avail at reset is not counted as an edge.
  - On the first cycle after reset deasserts, the state is FLUSH with the counter loaded to FLUSH_CYCLES.
- States: FLUSH, SETTLE, RUN, APPLY.
- RUN:
  - busy=0, out_enable=1, dsp_reset=0.
  - cfg_strobe at cycle T moves the state to APPLY at T+1. busy=1 and out_enable=0 from T+1.
- APPLY, 1 cycle:
  - Loads rx_freq ← shadow freq and rx_rate ← sanitised shadow rate (code > MAX_RATE_CODE → 0).
  - Clears settle_timeout.
  - If the sanitised rate differs from the current rx_rate, go to FLUSH. Otherwise go to SETTLE with target SETTLE_FREQ.
  - Net effect: a cfg_strobe in RUN updates rx_freq/rx_rate at T+2.
- FLUSH:
  - dsp_reset=1 for exactly FLUSH_CYCLES cycles, then SETTLE with target SETTLE_RATE.
  - decim_avail edges are ignored.
- SETTLE:
  - Counts rising edges of decim_avail.
  - On the cycle the count reaches the target, the state goes to RUN next cycle. cfg_done pulses on that first RUN cycle and out_enable rises in the same cycle.
  - A cycle counter runs from entry. Reaching TIMEOUT_CYCLES sets settle_timeout=1 and forces RUN (with the cfg_done pulse).
- Shadow registers:
  - cfg_strobe in any state captures cfg_freq/cfg_rate into shadow registers.
  - In FLUSH or SETTLE, cfg_strobe also aborts the current sequence: next state is APPLY, and counters reload on re-entry.
  - In APPLY, cfg_strobe overwrites the shadow and forces one extra APPLY cycle, so the last request always wins.
- Counters: FLUSH and settle counters saturate and never wrap. Use $clog2-sized widths plus 1.
- Reset mid-sequence: returns immediately to the reset values and discards any pending shadow contents.

Decomposition:
- Shared package rx_ctrl_pkg holds:
  - state enum;
  - rate code constants RATE_48K=0, RATE_96K=1, RATE_192K=2;
  - sanitise function for rate codes.
- Natural sub-module: rx_edge_counter. It does the decim_avail rising-edge detect plus a saturating count to a target, with load, clear and hit outputs.

Test Plan:
- Release reset with decim_avail toggling every 40 cycles:
  - dsp_reset high for 64 cycles;
  - out_enable rises and cfg_done pulses after the 8th edge;
  - rx_freq=0, rx_rate=0.
- In RUN, cfg_strobe with freq=7074000 and rate=0:
  - no dsp_reset;
  - rx_freq=7074000 at T+2;
  - out_enable low until 2 edges later, then cfg_done.
- In RUN, cfg_strobe with rate=2:
  - rx_rate=2 at T+2;
  - dsp_reset high for exactly 64 cycles;
  - 8 edges discarded.
- cfg_rate=5 → rx_rate=0. If the current rate was already 0, no flush occurs.
- During FLUSH, cfg_strobe with freq=14074000 and rate=1:
  - sequence restarts via APPLY;
  - final rx_freq=14074000, rx_rate=1;
  - full 64-cycle flush repeated.
- Hold decim_avail low in SETTLE:
  - after 65536 cycles, RUN is entered with settle_timeout=1 and a cfg_done pulse;
  - the next accepted cfg_strobe clears settle_timeout.
